spin_ctrl: RTL and testbench
============================

// Module: spin_ctrl
// PURPOSE
//   Sequencer for the segment driver. Produces the 3-bit wheel position (0..5 = segments A..F)
//   that feeds seg_driver's pos_i. Runs automatically at one of four speeds in either direction,
//   or steps one position per button press when stopped. Sits between top-level inputs and seg_driver.
// PARAMETERS
//   BASE_DIV  2        clk cycles per step at fastest speed (speed_i=3); must be >= 1
//   CNT_W     24       prescaler width; must satisfy BASE_DIV*8 <= 2**CNT_W
// PORTS
//   clk_i     in   1       system clock, all state on rising edge
//   rst_i     in   1       asynchronous, active-high reset
//   en_i      in   1       1 = auto-spin (RUN), 0 = stopped (STOP)
//   dir_i     in   1       0 = forward (A->B->..->F), 1 = reverse
//   speed_i   in   2       speed select, 3 fastest, 0 slowest
//   step_i    in   1       manual step request (debounced externally), rising-edge active
//   pos_o     out  3       wheel position 0..5, to seg_driver pos_i
//   tick_o    out  1       1-cycle pulse coincident with every pos_o update
//   lap_o     out  1       1-cycle pulse coincident with an update that wraps (5->0 or 0->5)
// BEHAVIOUR
//   - Reset (async, immediate): pos_o=0, tick_o=0, lap_o=0, state=STOP, prescaler=0,
//     step_q=0, speed_q=0. All outputs registered; no combinational path from inputs to outputs.
//   - PERIOD = BASE_DIV << (3 - speed_q): 1x, 2x, 4x, 8x BASE_DIV for speed 3, 2, 1, 0.
//   - Advance: dir_i=0 -> pos+1, 5 wraps to 0; dir_i=1 -> pos-1, 0 wraps to 5. dir_i sampled at
//     the advancing edge. pos_o of 6/7 (illegal) -> next advance yields 0, lap_o=0.
//   - On an advancing edge tick_o<=1 (lap_o<=1 if wrap); at every other edge both <=0.
//   - FSM, 2 states:
//     STOP: prescaler held at 0. If en_i=1 -> RUN (no advance this edge).
//           Else if step_i & ~step_q -> advance once. step_q <= step_i every edge.
//     RUN:  If en_i=0 -> STOP, prescaler<=0, no advance (en_i beats terminal count).
//           Else if speed_i != speed_q -> speed_q<=speed_i, prescaler<=0, no advance.
//           Else if prescaler == PERIOD-1 -> prescaler<=0, advance.
//           Else prescaler<=prescaler+1. step_i ignored (step_q still tracks step_i).
//   - First auto advance: exactly PERIOD edges after the edge that entered RUN.
//   - speed_q is also updated in STOP (no prescaler effect there).
//   - step_i held high: one advance only; needs a low cycle to re-arm. A step edge in the
//     same cycle as en_i 0->1 is dropped (RUN wins). step_q tracks in RUN, so a held button
//     at RUN->STOP does not fire.
//   - Reset mid-run: everything returns to reset values at once; after release the block is
//     in STOP at pos 0 and waits for en_i or a step edge.
// TESTING (BASE_DIV=2, CNT_W=8)
//   1. Assert rst_i between clk edges -> pos_o=0, tick_o=0, lap_o=0 before next edge; stays after release.
//   2. en=1, dir=0, speed=3 -> pos_o 1,2,3,4,5,0 every 2 cycles; tick_o each; lap_o only on 5->0.
//   3. From pos 0, en=1, dir=1, speed=0 -> first update after 16 cycles to 5 with lap_o=1, then 4.
//   4. en=0; step_i high 10 cycles, low 2, high 1 -> pos advances by exactly 2, one tick_o each.
//   5. RUN speed=0, switch to speed=3 after 10 cycles -> no update that edge; next update 2 cycles later.
//   6. Terminal count and en_i 1->0 in same cycle -> no advance, STOP; later step edge -> advance by 1.

Source files
------------

// File: rtl/spin_ctrl.sv
// spin_ctrl: wheel-position sequencer for seg_driver.
// Auto-spins at one of four speeds in either direction while enabled, or
// single-steps on rising edges of step_i while stopped. pos_o cycles 0..5.
module spin_ctrl #(
    parameter int BASE_DIV = 2,
    parameter int CNT_W    = 24
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       en_i,
    input  logic       dir_i,
    input  logic [1:0] speed_i,
    input  logic       step_i,
    output logic [2:0] pos_o,
    output logic       tick_o,
    output logic       lap_o
);

    typedef enum logic {
        ST_STOP = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   presc_q, presc_d;
    logic               step_q, step_d;
    logic [1:0]         speed_q, speed_d;
    logic [2:0]         pos_q, pos_d;
    logic               tick_q, tick_d;
    logic               lap_q, lap_d;

    logic               advance_s;
    logic [CNT_W-1:0]   period_s;
    logic [CNT_W-1:0]   term_s;
    logic [3:0]         next_s;

    // Next wheel position as {wrap, pos}; illegal positions recover to 0 without a lap.
    function automatic logic [3:0] next_pos(input logic [2:0] pos, input logic dir);
        logic [3:0] r;
        r = 4'b0000;
        if (pos > 3'd5) begin
            r = {1'b0, 3'd0};
        end else if (dir == 1'b0) begin
            if (pos == 3'd5) r = {1'b1, 3'd0};
            else             r = {1'b0, pos + 3'd1};
        end else begin
            if (pos == 3'd0) r = {1'b1, 3'd5};
            else             r = {1'b0, pos - 3'd1};
        end
        return r;
    endfunction

    // Step period scales BASE_DIV by 1x/2x/4x/8x for speed 3/2/1/0.
    always_comb begin
        period_s = CNT_W'(BASE_DIV) << (2'd3 - speed_q);
        term_s   = period_s - CNT_W'(1);
    end

    // FSM state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_STOP;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic: en_i alone selects RUN or STOP.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_STOP: begin
                if (en_i) state_d = ST_RUN;
                else      state_d = ST_STOP;
            end
            ST_RUN: begin
                if (!en_i) state_d = ST_STOP;
                else       state_d = ST_RUN;
            end
            default: state_d = ST_STOP;
        endcase
    end

    // FSM outputs: prescaler, speed latch, step edge detect and advance decision.
    always_comb begin
        advance_s = 1'b0;
        presc_d   = presc_q;
        speed_d   = speed_q;
        step_d    = step_i;
        case (state_q)
            ST_STOP: begin
                presc_d = '0;
                speed_d = speed_i;
                // Entering RUN takes priority over a coincident step edge.
                if (!en_i && step_i && !step_q) advance_s = 1'b1;
                else                            advance_s = 1'b0;
            end
            ST_RUN: begin
                if (!en_i) begin
                    presc_d = '0;
                end else if (speed_i != speed_q) begin
                    speed_d = speed_i;
                    presc_d = '0;
                end else if (presc_q == term_s) begin
                    presc_d   = '0;
                    advance_s = 1'b1;
                end else begin
                    presc_d = presc_q + CNT_W'(1);
                end
            end
            default: begin
                presc_d   = '0;
                advance_s = 1'b0;
            end
        endcase

        next_s = next_pos(pos_q, dir_i);
        if (advance_s) begin
            pos_d = next_s[2:0];
            lap_d = next_s[3];
        end else begin
            pos_d = pos_q;
            lap_d = 1'b0;
        end
        tick_d = advance_s;
    end

    // Datapath and output registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            presc_q <= '0;
            step_q  <= 1'b0;
            speed_q <= 2'd0;
            pos_q   <= 3'd0;
            tick_q  <= 1'b0;
            lap_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            step_q  <= step_d;
            speed_q <= speed_d;
            pos_q   <= pos_d;
            tick_q  <= tick_d;
            lap_q   <= lap_d;
        end
    end

    assign pos_o  = pos_q;
    assign tick_o = tick_q;
    assign lap_o  = lap_q;

endmodule

// File: tb/tb_spin_ctrl.sv
// Self-checking bench for spin_ctrl (BASE_DIV=2, CNT_W=8).
// Each scenario pushes expected {pos, lap, cycle} for every update it causes;
// a monitor pops and compares whenever tick_o is seen.
module tb_spin_ctrl;

    localparam int BASE_DIV = 2;
    localparam int CNT_W    = 8;

    logic       clk;
    logic       rst_i;
    logic       en_i;
    logic       dir_i;
    logic [1:0] speed_i;
    logic       step_i;
    logic [2:0] pos_o;
    logic       tick_o;
    logic       lap_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [2:0] pos;
        logic       lap;
        int         cyc;
    } exp_t;

    exp_t exp_q[$];

    spin_ctrl #(
        .BASE_DIV(BASE_DIV),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i  (clk),
        .rst_i  (rst_i),
        .en_i   (en_i),
        .dir_i  (dir_i),
        .speed_i(speed_i),
        .step_i (step_i),
        .pos_o  (pos_o),
        .tick_o (tick_o),
        .lap_o  (lap_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rising edges so expectations can name the edge that must update.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic push_exp(input logic [2:0] p, input logic l, input int c);
        exp_t e;
        e.pos = p;
        e.lap = l;
        e.cyc = c;
        exp_q.push_back(e);
    endtask

    // Scoreboard monitor: every tick must match the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (tick_o === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_tick got pos=%0d lap=%0b cyc=%0d want no update",
                             pos_o, lap_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (pos_o !== e.pos || lap_o !== e.lap || cyc != e.cyc) begin
                        errors++;
                        $display("FAIL update got pos=%0d lap=%0b cyc=%0d want pos=%0d lap=%0b cyc=%0d",
                                 pos_o, lap_o, cyc, e.pos, e.lap, e.cyc);
                    end
                end
            end else if (lap_o !== 1'b0 || tick_o !== 1'b0) begin
                checks++;
                errors++;
                $display("FAIL lap_without_tick got tick=%b lap=%b want 0 0", tick_o, lap_o);
            end
        end
    end

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (pos_o !== 3'd0 || tick_o !== 1'b0 || lap_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got pos=%0d tick=%b lap=%b want 0 0 0", pos_o, tick_o, lap_o);
        end
        rst_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pos_o !== 3'd0) begin
            errors++;
            $display("FAIL reset_release got pos=%0d want 0", pos_o);
        end
    endtask

    task automatic test_queue_empty(input string name, input logic [2:0] want_pos);
        checks++;
        if (exp_q.size() != 0 || pos_o !== want_pos) begin
            errors++;
            $display("FAIL %s_end got pending=%0d pos=%0d want pending=0 pos=%0d",
                     name, exp_q.size(), pos_o, want_pos);
            exp_q.delete();
        end
    endtask

    task automatic test_fwd_fast();
        int c;
        @(negedge clk);
        c = cyc;
        en_i = 1'b1; dir_i = 1'b0; speed_i = 2'd3;
        push_exp(3'd1, 1'b0, c + 3);
        push_exp(3'd2, 1'b0, c + 5);
        push_exp(3'd3, 1'b0, c + 7);
        push_exp(3'd4, 1'b0, c + 9);
        push_exp(3'd5, 1'b0, c + 11);
        push_exp(3'd0, 1'b1, c + 13);
        repeat (13) @(negedge clk);
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        test_queue_empty("fwd_fast", 3'd0);
    endtask

    task automatic test_rev_slow();
        int c;
        @(negedge clk);
        c = cyc;
        en_i = 1'b1; dir_i = 1'b1; speed_i = 2'd0;
        push_exp(3'd5, 1'b1, c + 17);
        push_exp(3'd4, 1'b0, c + 33);
        repeat (33) @(negedge clk);
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        test_queue_empty("rev_slow", 3'd4);
    endtask

    task automatic test_step_hold();
        int c;
        @(negedge clk);
        c = cyc;
        dir_i = 1'b0; step_i = 1'b1;
        push_exp(3'd5, 1'b0, c + 1);
        push_exp(3'd0, 1'b1, c + 13);
        repeat (10) @(negedge clk);
        step_i = 1'b0;
        repeat (2) @(negedge clk);
        step_i = 1'b1;
        @(negedge clk);
        step_i = 1'b0;
        repeat (4) @(negedge clk);
        test_queue_empty("step_hold", 3'd0);
    endtask

    task automatic test_speed_change();
        int c;
        @(negedge clk);
        c = cyc;
        en_i = 1'b1; dir_i = 1'b0; speed_i = 2'd0;
        repeat (10) @(negedge clk);
        speed_i = 2'd3;
        push_exp(3'd1, 1'b0, c + 13);
        push_exp(3'd2, 1'b0, c + 15);
        repeat (5) @(negedge clk);
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        test_queue_empty("speed_change", 3'd2);
    endtask

    task automatic test_en_beats_tc();
        int c;
        @(negedge clk);
        c = cyc;
        en_i = 1'b1; dir_i = 1'b0; speed_i = 2'd3;
        push_exp(3'd3, 1'b0, c + 3);
        repeat (4) @(negedge clk);
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pos_o !== 3'd3) begin
            errors++;
            $display("FAIL en_beats_tc got pos=%0d want 3", pos_o);
        end
        step_i = 1'b1;
        push_exp(3'd4, 1'b0, c + 9);
        @(negedge clk);
        step_i = 1'b0;
        repeat (3) @(negedge clk);
        test_queue_empty("en_tc_step", 3'd4);
    endtask

    task automatic test_step_corner();
        int c;
        @(negedge clk);
        c = cyc;
        en_i = 1'b1; step_i = 1'b1; dir_i = 1'b1; speed_i = 2'd3;
        push_exp(3'd3, 1'b0, c + 3);
        push_exp(3'd2, 1'b0, c + 5);
        repeat (5) @(negedge clk);
        en_i = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (pos_o !== 3'd2) begin
            errors++;
            $display("FAIL held_step_at_stop got pos=%0d want 2", pos_o);
        end
        step_i = 1'b0;
        repeat (2) @(negedge clk);
        test_queue_empty("step_corner", 3'd2);
    endtask

    task automatic test_reset_midrun();
        int c;
        @(negedge clk);
        c = cyc;
        en_i = 1'b1; dir_i = 1'b0; speed_i = 2'd3;
        push_exp(3'd3, 1'b0, c + 3);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2;
        checks++;
        if (pos_o !== 3'd4 || tick_o !== 1'b1) begin
            errors++;
            $display("FAIL pre_reset_update got pos=%0d tick=%b want 4 1", pos_o, tick_o);
        end
        rst_i = 1'b1;
        #1;
        checks++;
        if (pos_o !== 3'd0 || tick_o !== 1'b0 || lap_o !== 1'b0) begin
            errors++;
            $display("FAIL async_reset got pos=%0d tick=%b lap=%b want 0 0 0", pos_o, tick_o, lap_o);
        end
        en_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
        repeat (5) @(negedge clk);
        test_queue_empty("reset_midrun", 3'd0);
    endtask

    initial begin
        rst_i   = 1'b1;
        en_i    = 1'b0;
        dir_i   = 1'b0;
        speed_i = 2'd0;
        step_i  = 1'b0;
        test_reset();
        test_fwd_fast();
        test_rev_slow();
        test_step_hold();
        test_speed_change();
        test_en_beats_tc();
        test_step_corner();
        test_reset_midrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
